// File: rtl/dm_bytelane_pkg.sv
// Shared constants and helpers for the byte-lane data memory.
//   SIZE_*  : access-size encodings carried on size_i
//   state_e : clear sequencer states
//   lane_be / is_aligned / store_data : decode helpers used by the top
package dm_bytelane_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_B:  be = 4'(4'b0001 << lane);
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Natural alignment; size 11 never aligns.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~lane[0];
      SIZE_W:  ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate the low sub-word across the word so every lane sees it.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] din);
    logic [31:0] wd;
    wd = din;
    case (size)
      SIZE_B:  wd = {4{din[7:0]}};
      SIZE_H:  wd = {2{din[15:0]}};
      default: wd = din;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load alignment/extension: picks the byte or half at lane_i out of word_i,
// right-justifies it and sign- or zero-extends it; words pass through.
//   word_i : full 32-bit memory word
//   lane_i : byte lane (addr[1:0])
//   size_i : access size
//   uns_i  : 1 = zero-extend, 0 = sign-extend
//   ext_o  : extended result (combinational)
module dm_load_ext
  import dm_bytelane_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    ext_o = word_i;
    case (size_i)
      SIZE_B:  ext_o = uns_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  ext_o = uns_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: byte/half/word stores through
// byte enables, extended sub-word loads with one cycle of latency, a
// post-reset clear sequencer and a misalignment pulse.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i, we_i           : access request, 1 = store
//   addr_i, size_i, uns_i : byte address, access size, zero-extend select
//   din_i                 : store data (sub-word in the low bits)
//   dout_o, rvalid_o      : load data and its one-cycle valid
//   busy_o                : clear in progress, requests ignored
//   misalign_o            : pulse after a misaligned or illegal request
module dm_bytelane
  import dm_bytelane_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [31:0]       din_i,
  output logic [31:0]       dout_o,
  output logic              rvalid_o,
  output logic              busy_o,
  output logic              misalign_o
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [31:0] mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dout_q;
  logic             rvalid_q, busy_q, busy_d, misalign_q;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      ld_ext;
  logic             clr_we, st_we, ld_go, bad_go;

  assign idx   = addr_i[ADDR_W-1:2];
  assign lane  = addr_i[1:0];
  assign be    = lane_be(size_i, lane);
  assign wdata = store_data(size_i, din_i);

  // Extension sits in front of the dout register.
  dm_load_ext u_ext (
    .word_i (mem_q[idx]),
    .lane_i (lane),
    .size_i (size_i),
    .uns_i  (uns_i),
    .ext_o  (ld_ext)
  );

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    clr_we  = 1'b0;
    st_we   = 1'b0;
    ld_go   = 1'b0;
    bad_go  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = IDX_W'(cnt_q + 1'b1);
        busy_d = 1'b1;
        // Last word written this cycle: busy drops together with the state.
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        if (req_i) begin
          if (is_aligned(size_i, lane)) begin
            st_we = we_i;
            ld_go = ~we_i;
          end else begin
            bad_go = 1'b1;
          end
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      cnt_q      <= '0;
      busy_q     <= CLEAR_ON_RST;
      dout_q     <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rvalid_q   <= ld_go;
      misalign_q <= bad_go;
      if (ld_go) dout_q <= ld_ext;
    end
  end

  // Storage array: clear writes whole words, stores write enabled lanes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end else if (st_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign dout_o     = dout_q;
  assign rvalid_o   = rvalid_q;
  assign busy_o     = busy_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dm_bytelane.sv
module tb_dm_bytelane;

  logic        clk, rst, req, we, uns;
  logic [5:0]  addr;
  logic [1:0]  size;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rvalid, busy, misalign;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_dout;
  logic [31:0] ref_mem [16];

  dm_bytelane #(.ADDR_W(6), .CLEAR_ON_RST(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .size_i     (size),
    .uns_i      (uns),
    .din_i      (din),
    .dout_o     (dout),
    .rvalid_o   (rvalid),
    .busy_o     (busy),
    .misalign_o (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs at a negedge; outputs are sampled at the next negedge.
  task automatic step(input logic r, input logic w, input logic [5:0] a,
                      input logic [1:0] s, input logic u, input logic [31:0] d);
    req = r; we = w; addr = a; size = s; uns = u; din = d;
    @(negedge clk);
  endtask

  task automatic model_store(input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] mask, val;
    int sh;
    sh = 8 * int'(a[1:0]);
    if (s == 2'b00) begin mask = 32'h0000_00FF << sh; val = (d & 32'hFF) << sh; end
    else if (s == 2'b01) begin mask = 32'h0000_FFFF << sh; val = (d & 32'hFFFF) << sh; end
    else begin mask = 32'hFFFF_FFFF; val = d; end
    ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~mask) | val;
  endtask

  function automatic logic [31:0] model_load(input logic [5:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v;
    v = ref_mem[a[5:2]] >> (8 * int'(a[1:0]));
    if (s == 2'b00) return u ? (v & 32'hFF) : 32'($signed(v[7:0]));
    if (s == 2'b01) return u ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
    return v;
  endfunction

  task automatic test_reset;
    int n;
    logic [31:0] e;
    rst = 1'b1;
    step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    vectors++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || misalign !== 1'b0 || dout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state busy=%b rvalid=%b misalign=%b dout=%h, want 1 0 0 00000000",
               busy, rvalid, misalign, dout);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step(1, 0, 6'h3C, 2'b10, 0, 32'h0);
      vectors++;
      if (rvalid !== 1'b0 || dout !== 32'h0) begin
        miscompares++;
        $display("FAIL load_while_busy rvalid=%b dout=%h, want 0 00000000", rvalid, dout);
      end
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL busy_length got %0d cycles, want 16", n);
    end
    exp_q.push_back(32'h0);
    step(1, 0, 6'h3C, 2'b10, 0, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (rvalid !== 1'b1 || dout !== e) begin
      miscompares++;
      $display("FAIL load_after_clear rvalid=%b dout=%h, want 1 %h", rvalid, dout, e);
    end
    last_dout = e;
    step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    vectors++;
    if (rvalid !== 1'b0 || dout !== last_dout) begin
      miscompares++;
      $display("FAIL rvalid_pulse rvalid=%b dout=%h, want 0 %h", rvalid, dout, last_dout);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic test_lane_merge;
    logic [5:0]  la [4] = '{6'h08, 6'h09, 6'h09, 6'h0A};
    logic [1:0]  ls [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    logic        lu [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] le [4] = '{32'hBEEFAA44, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBEEF};
    logic [31:0] e;
    step(1, 1, 6'h08, 2'b10, 0, 32'h11223344); model_store(6'h08, 2'b10, 32'h11223344);
    step(1, 1, 6'h09, 2'b00, 0, 32'h000000AA); model_store(6'h09, 2'b00, 32'h000000AA);
    step(1, 1, 6'h0A, 2'b01, 0, 32'h0000BEEF); model_store(6'h0A, 2'b01, 32'h0000BEEF);
    vectors++;
    if (rvalid !== 1'b0 || dout !== last_dout) begin
      miscompares++;
      $display("FAIL store_no_rvalid rvalid=%b dout=%h, want 0 %h", rvalid, dout, last_dout);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(le[i]);
      step(1, 0, la[i], ls[i], lu[i], 32'h0);
      e = exp_q.pop_front();
      vectors++;
      if (rvalid !== 1'b1 || dout !== e) begin
        miscompares++;
        $display("FAIL lane_load%0d rvalid=%b dout=%h, want 1 %h", i, rvalid, dout, e);
      end
      last_dout = e;
    end
  endtask

  task automatic test_misalign;
    logic [5:0]  ba [3] = '{6'h05, 6'h06, 6'h00};
    logic [1:0]  bs [3] = '{2'b01, 2'b10, 2'b11};
    logic        bw [3] = '{1'b1, 1'b0, 1'b1};
    logic [5:0]  ca [2] = '{6'h04, 6'h00};
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      step(1, bw[i], ba[i], bs[i], 0, 32'hFFFFFFFF);
      vectors++;
      if (misalign !== 1'b1 || rvalid !== 1'b0 || dout !== last_dout) begin
        miscompares++;
        $display("FAIL misalign%0d misalign=%b rvalid=%b dout=%h, want 1 0 %h",
                 i, misalign, rvalid, dout, last_dout);
      end
      step(0, 0, 6'h00, 2'b00, 0, 32'h0);
      vectors++;
      if (misalign !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign_pulse%0d misalign=%b, want 0", i, misalign);
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0);
      step(1, 0, ca[i], 2'b10, 0, 32'h0);
      e = exp_q.pop_front();
      vectors++;
      if (rvalid !== 1'b1 || dout !== e) begin
        miscompares++;
        $display("FAIL mem_unchanged%0d rvalid=%b dout=%h, want 1 %h", i, rvalid, dout, e);
      end
      last_dout = e;
    end
  endtask

  task automatic test_raw;
    logic [31:0] e;
    step(1, 1, 6'h10, 2'b10, 0, 32'hCAFEF00D); model_store(6'h10, 2'b10, 32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    step(1, 0, 6'h10, 2'b10, 0, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (rvalid !== 1'b1 || dout !== e) begin
      miscompares++;
      $display("FAIL read_after_write rvalid=%b dout=%h, want 1 %h", rvalid, dout, e);
    end
    last_dout = e;
  endtask

  task automatic test_back_to_back;
    logic [5:0]  a;
    logic [1:0]  s;
    logic        u;
    logic [31:0] d, e;
    for (int i = 0; i < 10; i++) begin
      s = 2'($urandom_range(2, 0));
      a = {4'($urandom_range(14, 5)), 2'($urandom_range(3, 0))};
      if (s == 2'b01) a[0] = 1'b0;
      if (s == 2'b10) a[1:0] = 2'b00;
      d = $urandom;
      step(1, 1, a, s, 0, d);
      model_store(a, s, d);
    end
    for (int i = 0; i < 12; i++) begin
      s = 2'($urandom_range(2, 0));
      u = 1'($urandom_range(1, 0));
      a = {4'($urandom_range(14, 5)), 2'($urandom_range(3, 0))};
      if (s == 2'b01) a[0] = 1'b0;
      if (s == 2'b10) a[1:0] = 2'b00;
      exp_q.push_back(model_load(a, s, u));
      step(1, 0, a, s, u, 32'h0);
      e = exp_q.pop_front();
      vectors++;
      if (rvalid !== 1'b1 || dout !== e) begin
        miscompares++;
        $display("FAIL b2b_load%0d addr=%h size=%0d uns=%b rvalid=%b dout=%h, want 1 %h",
                 i, a, s, u, rvalid, dout, e);
      end
      last_dout = e;
    end
  endtask

  task automatic test_reset_midclear;
    int n;
    logic [31:0] e;
    logic [5:0] ca [2] = '{6'h08, 6'h10};
    rst = 1'b1;
    step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    rst = 1'b1;
    step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step(0, 0, 6'h00, 2'b00, 0, 32'h0);
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL midclear_busy_length got %0d cycles, want 16", n);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0);
      step(1, 0, ca[i], 2'b10, 0, 32'h0);
      e = exp_q.pop_front();
      vectors++;
      if (rvalid !== 1'b1 || dout !== e) begin
        miscompares++;
        $display("FAIL midclear_zero%0d rvalid=%b dout=%h, want 1 %h", i, rvalid, dout, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; uns = 1'b0; din = '0;
    last_dout = '0;
    @(negedge clk);
    test_reset;
    test_lane_merge;
    test_misalign;
    test_raw;
    test_back_to_back;
    test_reset_midclear;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
